// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory:
// FSM encoding, default geometry and byte-lane helpers (big-endian lane order).
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int WORD_BYTES  = 4;

  // Lane 0 carries word bits [31:24] and lands at the lowest byte address.
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    lane_byte = w[31:24];
    case (k)
      2'd0: lane_byte = w[31:24];
      2'd1: lane_byte = w[23:16];
      2'd2: lane_byte = w[15:8];
      2'd3: lane_byte = w[7:0];
      default: lane_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, one byte
// per cycle, MSB first, holding the CPU off the memory while a session runs.
//
// Handshake: a word transfers on a rising edge where word_valid && word_ready;
// word_ready depends only on the FSM state (ACCEPT), never on word_valid.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] word_count,
  output logic              wrap_err,
  output logic [1:0]        dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_wrapped;
  logic [31:0]       word_q;
  logic              last_q;
  logic [1:0]        byte_idx;
  logic [1:0]        byte_nxt;
  logic [ADDR_W:0]   ptr_sum;

  assign byte_nxt  = byte_idx + 2'd1;
  assign ptr_sum   = {1'b0, ptr} + (ADDR_W+1)'(WORD_BYTES);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        word_ready = 1'b1;
        if (word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (byte_idx == LANE_LAST) state_d = last_q ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port is registered: the handshake edge already presents lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      ptr_wrapped <= 1'b0;
      word_q      <= '0;
      last_q      <= 1'b0;
      byte_idx    <= LANE_FIRST;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      word_count  <= '0;
      wrap_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr         <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
            ptr_wrapped <= 1'b0;
            word_count  <= '0;
            wrap_err    <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (word_valid) begin
            word_q    <= word_data;
            last_q    <= word_last;
            byte_idx  <= LANE_FIRST;
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= lane_byte(word_data, LANE_FIRST);
            // Flag only once a byte actually lands at a wrapped address.
            if (ptr_wrapped) wrap_err <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (byte_idx != LANE_LAST) begin
            byte_idx  <= byte_nxt;
            mem_we    <= 1'b1;
            mem_addr  <= ptr + ADDR_W'(byte_nxt);
            mem_wdata <= lane_byte(word_q, byte_nxt);
          end else begin
            ptr         <= ptr_sum[ADDR_W-1:0];
            ptr_wrapped <= ptr_wrapped | ptr_sum[ADDR_W];
            if (word_count != '1) word_count <= word_count + (ADDR_W-1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus tasks push expected byte writes
// (cycle, address, data) into a queue; an independent monitor pops and compares.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = 32 + ADDR_W + 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-2:0] word_count;
  logic              wrap_err;
  logic [1:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .wrap_err   (wrap_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [ADDR_W-1:0] m_ptr   = '0;
  int                last_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset && mem_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h at cycle %0d, required no write",
                 mem_addr, mem_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e[EW-1:ADDR_W+8] != 32'(cyc) || e[ADDR_W+7:8] != mem_addr || e[7:0] != mem_wdata) begin
          n_fail++;
          $display("FAIL byte_write: got cyc=%0d addr=0x%0h data=0x%0h, required cyc=%0d addr=0x%0h data=0x%0h",
                   cyc, mem_addr, mem_wdata, e[EW-1:ADDR_W+8], e[ADDR_W+7:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic start_session(input logic [ADDR_W-1:0] base);
    start     = 1'b1;
    base_addr = base;
    m_ptr     = base & ~ADDR_W'(3);
    @(negedge clk);
    start     = 1'b0;
    base_addr = '0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic keep);
    int                n;
    logic              got;
    logic [ADDR_W-1:0] a;
    logic [7:0]        b;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      if (word_ready) begin
        got     = 1'b1;
        last_hs = cyc;
        for (int k = 0; k < 4; k++) begin
          a = m_ptr + ADDR_W'(k);
          b = 8'(d >> (24 - 8 * k));
          exp_q.push_back({32'(cyc + 1 + k), a, b});
        end
        m_ptr = m_ptr + ADDR_W'(4);
      end
      @(negedge clk);
      n++;
    end
    check("word_accepted", {31'd0, got}, 32'd1);
    if (!keep) word_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    if (done) check("done_cycle", 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int h0, h1, h2, cnt;
    reset      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_word_ready", {31'd0, word_ready}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   32'(mem_addr),       32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),      32'd0);
    check("rst_word_count", 32'(word_count),     32'd0);
    check("rst_wrap_err",   {31'd0, wrap_err},   32'd0);
    check("rst_state",      32'(dbg_state),      32'(ST_IDLE));

    // Single word at base 0; start accepted on the first edge after release
    reset = 1'b1;
    start_session(10'd0);
    check("first_start_busy",  {31'd0, busy},  32'd1);
    check("first_start_state", 32'(dbg_state), 32'(ST_ACCEPT));
    send_word(32'h8D61000C, 1'b1, 1'b0);
    wait_done(last_hs + 5);
    check("single_word_count", 32'(word_count), 32'd1);
    check("single_wrap_err",   {31'd0, wrap_err}, 32'd0);

    // Three back-to-back words at base 8, valid held high
    @(negedge clk);
    start_session(10'd8);
    send_word(32'h11223344, 1'b0, 1'b1);
    h0 = last_hs;
    send_word(32'hA5A55A5A, 1'b0, 1'b1);
    h1 = last_hs;
    send_word(32'hDEADBEEF, 1'b1, 1'b0);
    h2 = last_hs;
    check("ready_spacing_1", 32'(h1 - h0), 32'd5);
    check("ready_spacing_2", 32'(h2 - h1), 32'd5);
    wait_done(last_hs + 5);
    check("b2b_word_count", 32'(word_count),   32'd3);
    check("b2b_wrap_err",   {31'd0, wrap_err}, 32'd0);

    // Top-of-memory wrap: base 1022 aligns to 1020, second word lands at 0..3
    @(negedge clk);
    start_session(10'd1022);
    send_word(32'h01020304, 1'b0, 1'b1);
    send_word(32'hCAFEF00D, 1'b1, 1'b0);
    wait_done(last_hs + 5);
    check("wrap_err_set",    {31'd0, wrap_err}, 32'd1);
    check("wrap_word_count", 32'(word_count),   32'd2);
    repeat (3) @(negedge clk);
    check("wrap_err_holds",  {31'd0, wrap_err}, 32'd1);

    // Start during WRITE is ignored; addresses continue from 44
    start_session(10'd40);
    check("wrap_err_cleared_by_start", {31'd0, wrap_err}, 32'd0);
    send_word(32'h0BADC0DE, 1'b0, 1'b0);
    start     = 1'b1;
    base_addr = 10'd100;
    @(negedge clk);
    start     = 1'b0;
    base_addr = '0;
    send_word(32'h76543210, 1'b1, 1'b0);
    wait_done(last_hs + 5);
    check("ign_start_word_count", 32'(word_count), 32'd2);

    // Reset while byte 2 is on the write port
    @(negedge clk);
    start_session(10'd0);
    send_word(32'h13579BDF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_mem_we",     {31'd0, mem_we},     32'd0);
    check("midrst_busy",       {31'd0, busy},       32'd0);
    check("midrst_word_ready", {31'd0, word_ready}, 32'd0);
    check("midrst_pending",    32'(exp_q.size()),   32'd2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("midrst_no_done_busy", 32'(cnt),        32'd0);
    check("midrst_word_count",   32'(word_count), 32'd0);

    // Upstream word offered in IDLE is never acknowledged nor written
    word_valid = 1'b1;
    word_data  = 32'hFFFFFFFF;
    word_last  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (word_ready || mem_we) cnt++;
    end
    word_valid = 1'b0;
    check("idle_valid_ignored", 32'(cnt),        32'd0);
    check("idle_valid_busy",    {31'd0, busy},   32'd0);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, is the byte-address width of the target instruction memory.
REQ-002 Parameter WORD_BYTES, default 4, is the bytes per instruction word; fixed, not overridable in this revision.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to open a load session.
REQ-006 base_addr  input  ADDR_W  session start byte address; sampled with start.
REQ-007 word_valid  input  1  upstream word present.
REQ-008 word_data  input  32  instruction word; bit 31 is the MSB.
REQ-009 word_last  input  1  word is the final one of the session; qualified by word_valid.
REQ-010 word_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_we  output  1  byte write strobe to instruction memory.
REQ-012 mem_addr  output  ADDR_W  byte write address.
REQ-013 mem_wdata  output  8  byte write data.
REQ-014 busy  output  1  session in progress; holds CPU off instruction memory.
REQ-015 done  output  1  one-cycle pulse at session end.
REQ-016 word_count  output  ADDR_W-1  words written in current/last session.
REQ-017 wrap_err  output  1  sticky: session wrapped past the top address.

Function
REQ-018 States SHALL be IDLE, ACCEPT, WRITE, DONE.
REQ-019 IDLE: start=1 SHALL load ptr={base_addr[ADDR_W-1:2],2'b00}, clear word_count and wrap_err, go to ACCEPT; base_addr[1:0] ignored.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 word_ready SHALL be 1 only in ACCEPT, combinationally independent of word_valid.
REQ-022 word_valid&word_ready SHALL capture word_data and word_last and go to WRITE.
REQ-023 WRITE SHALL last exactly 4 cycles; byte index k=0..3 drives mem_we=1, mem_addr=ptr+k, mem_wdata=word_data[31-8k -: 8] (big-endian: MSB at lowest address).
REQ-024 First byte write SHALL occur the cycle after the handshake; all write outputs are registered.
REQ-025 After k=3: word_count increments, ptr advances by 4, next state DONE if captured last=1 else ACCEPT.
REQ-026 Sustained throughput SHALL be one word per 5 cycles (1 ACCEPT + 4 WRITE).
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; ptr+k crossing from all-ones to 0 SHALL set wrap_err and continue writing at wrapped address.
REQ-028 word_count SHALL saturate at all-ones; no wrap.
REQ-029 DONE SHALL assert done for one cycle, then return to IDLE; busy=1 in ACCEPT, WRITE, DONE.
REQ-030 mem_we SHALL be 0 in all states except WRITE; mem_addr/mem_wdata hold last value when mem_we=0.
REQ-031 word_count and wrap_err SHALL hold after DONE until next accepted start.
REQ-032 word_valid without session (IDLE) SHALL be ignored and never acknowledged.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, word_count=0, wrap_err=0, word_ready=0.
REQ-034 Reset mid-WRITE SHALL abort the word; partially written bytes are not rolled back.
REQ-035 First start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-036 Package imem_pkg SHALL hold the state enum, ADDR_W default, WORD_BYTES and byte-lane index constants, shared with the instruction memory.
REQ-037 Single module; no sub-module, byte serialisation is a 2-bit counter in the FSM.

Verification
REQ-038 base=0, one word 0x8D61000C last=1 -> cycles +1..+4: (0,0x8D),(1,0x61),(2,0x00),(3,0x0C); done at +5; word_count=1.
REQ-039 base=8, three back-to-back words, valid held high -> word_ready pulses every 5 cycles, addresses 8..19 contiguous, word_count=3.
REQ-040 base=1022 -> ptr=1020; two words -> second writes 1024..1027 as 0..3, wrap_err=1 after done.
REQ-041 start during WRITE with base=100 -> ignored; addresses continue from original ptr.
REQ-042 reset=0 at byte k=2 -> mem_we=0 same cycle; after release busy=0, no done, word_count=0.
REQ-043 word_valid=1 with word_data=0xFFFFFFFF in IDLE for 10 cycles -> word_ready=0, mem_we never asserted.
